// File: rtl/acia_pkg.sv
// Shared ACIA definitions: register bit positions, register-select encodings,
// bit timing default and the status-byte packing helper.
package acia_pkg;

    localparam int ACIA_BIT_PCLKS = 35;

    localparam int SR_RDRF = 0;
    localparam int SR_TDRE = 1;
    localparam int SR_FE   = 4;
    localparam int SR_OVRN = 5;
    localparam int SR_IRQ  = 7;

    localparam int         CR_RIE          = 7;
    localparam logic [1:0] CR_TIE_ON       = 2'b01;
    localparam logic [1:0] CR_MASTER_RESET = 2'b11;

    localparam logic RS_CTRL = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [7:0] status_pack(input logic irq, input logic ovrn,
                                               input logic fe, input logic tdre,
                                               input logic rdrf);
        logic [7:0] s;
        s          = 8'h00;
        s[SR_IRQ]  = irq;
        s[SR_OVRN] = ovrn;
        s[SR_FE]   = fe;
        s[SR_TDRE] = tdre;
        s[SR_RDRF] = rdrf;
        return s;
    endfunction

endpackage

// File: rtl/acia_rx.sv
// ACIA receiver: rx synchronizer, start-bit detect with mid-bit recheck,
// LSB-first sampling and stop-bit framing check. done_o pulses for one clk per byte.
module acia_rx
    import acia_pkg::*;
#(
    parameter int BIT_PCLKS = ACIA_BIT_PCLKS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       srst_i,
    input  logic       pclk_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       fe_o,
    output logic       done_o
);

    localparam int            CW       = (BIT_PCLKS > 2) ? $clog2(BIT_PCLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PCLKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_PCLKS / 2 - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    data_q, data_d;
    logic          fe_q, fe_d;
    logic          done_q, done_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic          fall_s;

    assign rx_s   = sync_q[1];
    assign fall_s = prev_q & ~rx_s;

    // State, synchronizer and edge-detect registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
        end else if (srst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
        end
    end

    // Receive sequencing: start check at half a bit, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = data_q;
        fe_d    = fe_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RX_START: begin
                if (pclk_i && (cnt_q == CNT_HALF)) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else if (pclk_i) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RX_DATA: begin
                if (pclk_i && (cnt_q == CNT_LAST)) begin
                    cnt_d = '0;
                    sr_d  = {rx_s, sr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else if (pclk_i) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RX_STOP: begin
                if (pclk_i && (cnt_q == CNT_LAST)) begin
                    cnt_d   = '0;
                    data_d  = sr_q;
                    fe_d    = ~rx_s;
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end else if (pclk_i) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data_o = data_q;
    assign fe_o   = fe_q;
    assign done_o = done_q;

endmodule

// File: rtl/acia.sv
// ACIA top: CPU bus interface, control/status/data registers, transmitter and IRQ.
// While the control register holds the master-reset code all other state is held reset.
module acia
    import acia_pkg::*;
#(
    parameter int BIT_PCLKS = ACIA_BIT_PCLKS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pclk,
    input  logic       cs_n,
    input  logic       we_n,
    input  logic       rs,
    input  logic       rx,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       tx,
    output logic       irq_n
);

    localparam int            CW       = (BIT_PCLKS > 2) ? $clog2(BIT_PCLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PCLKS - 1);

    logic [7:0]    ctrl_q, ctrl_d, thr_q, thr_d, rdr_q, rdr_d, dout_q, dout_d;
    logic          tdre_q, tdre_d, rdrf_q, rdrf_d, ovrn_q, ovrn_d, fe_q, fe_d;
    logic          tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic [8:0]    tx_sr_q, tx_sr_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          wr_s, rd_s, rd_data_s, mr_s, mr_wr_s, srst_s, irq_s, tx_load_s;
    logic [7:0]    status_s, rx_data_s;
    logic          rx_fe_s, rx_done_s;

    assign wr_s      = ~cs_n & ~we_n;
    assign rd_s      = ~cs_n & we_n;
    assign rd_data_s = rd_s & (rs == RS_DATA);
    assign mr_s      = (ctrl_q[1:0] == CR_MASTER_RESET);
    assign mr_wr_s   = wr_s & (rs == RS_CTRL) & (din[1:0] == CR_MASTER_RESET);
    assign srst_s    = mr_s | mr_wr_s;
    assign irq_s     = ~mr_s & ((ctrl_q[CR_RIE] & rdrf_q) |
                                ((ctrl_q[6:5] == CR_TIE_ON) & tdre_q));
    assign status_s  = status_pack(irq_s, ovrn_q, fe_q, tdre_q, rdrf_q);

    acia_rx #(.BIT_PCLKS(BIT_PCLKS)) u_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .srst_i  (srst_s),
        .pclk_i  (pclk),
        .rx_i    (rx),
        .data_o  (rx_data_s),
        .fe_o    (rx_fe_s),
        .done_o  (rx_done_s)
    );

    // Register file, transmitter and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= 8'h00;
            dout_q    <= 8'h00;
            thr_q     <= 8'h00;
            rdr_q     <= 8'h00;
            tdre_q    <= 1'b1;
            rdrf_q    <= 1'b0;
            ovrn_q    <= 1'b0;
            fe_q      <= 1'b0;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_sr_q   <= 9'h1FF;
            tx_bits_q <= 4'd0;
            tx_cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            dout_q <= dout_d;
            if (srst_s) begin
                thr_q     <= 8'h00;
                rdr_q     <= 8'h00;
                tdre_q    <= 1'b1;
                rdrf_q    <= 1'b0;
                ovrn_q    <= 1'b0;
                fe_q      <= 1'b0;
                tx_q      <= 1'b1;
                tx_busy_q <= 1'b0;
                tx_sr_q   <= 9'h1FF;
                tx_bits_q <= 4'd0;
                tx_cnt_q  <= '0;
            end else begin
                thr_q     <= thr_d;
                rdr_q     <= rdr_d;
                tdre_q    <= tdre_d;
                rdrf_q    <= rdrf_d;
                ovrn_q    <= ovrn_d;
                fe_q      <= fe_d;
                tx_q      <= tx_d;
                tx_busy_q <= tx_busy_d;
                tx_sr_q   <= tx_sr_d;
                tx_bits_q <= tx_bits_d;
                tx_cnt_q  <= tx_cnt_d;
            end
        end
    end

    // Next-state: TX shifter, bus writes/reads and receive flag handling.
    always_comb begin
        ctrl_d    = ctrl_q;
        thr_d     = thr_q;
        rdr_d     = rdr_q;
        dout_d    = dout_q;
        tdre_d    = tdre_q;
        rdrf_d    = rdrf_q;
        ovrn_d    = ovrn_q;
        fe_d      = fe_q;
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_sr_d   = tx_sr_q;
        tx_bits_d = tx_bits_q;
        tx_cnt_d  = tx_cnt_q;
        tx_load_s = 1'b0;

        if (!tx_busy_q) begin
            tx_load_s = ~tdre_q;
        end else if (pclk && (tx_cnt_q == CNT_LAST)) begin
            tx_cnt_d = '0;
            if (tx_bits_q != 4'd0) begin
                tx_d      = tx_sr_q[0];
                tx_sr_d   = {1'b1, tx_sr_q[8:1]};
                tx_bits_d = tx_bits_q - 4'd1;
            end else if (!tdre_q) begin
                tx_load_s = 1'b1;
            end else begin
                tx_busy_d = 1'b0;
                tx_d      = 1'b1;
            end
        end else if (pclk) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else begin
            tx_cnt_d = tx_cnt_q;
        end

        // A load drives the start bit immediately; remaining 9 bits are data then stop.
        if (tx_load_s) begin
            tx_busy_d = 1'b1;
            tx_d      = 1'b0;
            tx_sr_d   = {1'b1, thr_q};
            tx_bits_d = 4'd9;
            tx_cnt_d  = '0;
            tdre_d    = 1'b1;
        end else begin
            tx_busy_d = tx_busy_d;
        end

        if (wr_s && (rs == RS_DATA)) begin
            thr_d  = din;
            tdre_d = 1'b0;
        end else if (wr_s) begin
            ctrl_d = din;
        end else begin
            ctrl_d = ctrl_q;
        end

        // A completing byte beats a same-edge data read.
        if (rx_done_s) begin
            rdr_d  = rx_data_s;
            fe_d   = rx_fe_s;
            rdrf_d = 1'b1;
            if (rdrf_q && !rd_data_s) begin
                ovrn_d = 1'b1;
            end else begin
                ovrn_d = ovrn_q;
            end
        end else if (rd_data_s) begin
            rdrf_d = 1'b0;
            ovrn_d = 1'b0;
        end else begin
            rdrf_d = rdrf_q;
        end

        if (rd_s) begin
            dout_d = (rs == RS_DATA) ? rdr_q : status_s;
        end else if (mr_wr_s) begin
            dout_d = 8'h00;
        end else begin
            dout_d = dout_q;
        end
    end

    assign dout  = dout_q;
    assign tx    = tx_q;
    assign irq_n = ~irq_s;

endmodule

// File: tb/tb_acia.sv
// Directed bench for acia: reset, control/IRQ vector table, TX framing,
// RX with interrupt, overrun, framing error, mid-frame reset, false start, master reset.
module tb_acia;

    localparam int BP = 35;

    logic       clk, reset_n, pclk, cs_n, we_n, rs, rx;
    logic [7:0] din, dout;
    logic       tx, irq_n;

    int n_checks = 0;
    int n_fail   = 0;

    acia #(.BIT_PCLKS(BP)) dut (
        .clk(clk), .reset_n(reset_n), .pclk(pclk), .cs_n(cs_n), .we_n(we_n),
        .rs(rs), .rx(rx), .din(din), .dout(dout), .tx(tx), .irq_n(irq_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pclk is high for every second rising clk edge
    initial begin
        pclk = 1'b0;
        forever begin
            @(negedge clk);
            pclk = ~pclk;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] ctrl;
        logic       exp_irq_n;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[9];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bus tasks are entered at a negedge and return at a negedge.
    task automatic wr(input logic r, input logic [7:0] d);
        cs_n = 1'b0; we_n = 1'b0; rs = r; din = d;
        @(negedge clk);
        cs_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic rd(input logic r, output logic [7:0] d);
        cs_n = 1'b0; we_n = 1'b1; rs = r;
        @(negedge clk);
        cs_n = 1'b1;
        d = dout;
    endtask

    task automatic wait_pulses(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            #1;
            if (pclk) k++;
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        wait_pulses(n);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0, BP);
        for (int i = 0; i < 8; i++) send_bit(b[i], BP);
        send_bit(stop, BP);
        if (!stop) send_bit(1'b1, 4);
    endtask

    // Watches tx from the shifter load: each edge must land on a multiple of BP pulses.
    task automatic tx_monitor(input logic [7:0] b);
        logic [9:0] frame;
        logic       prev;
        int pulses = 0, nt = 0, guard = 0;
        frame = {1'b1, b, 1'b0};
        while (tx !== 1'b0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check8("tx_start_bit", {7'd0, tx}, 8'h00);
        prev = 1'b0;
        while (pulses < 10 * BP + 10) begin
            @(posedge clk);
            #1;
            if (pclk) pulses++;
            if (tx !== prev) begin
                nt++;
                check_int("tx_edge_pulse", pulses, BP * nt);
                check8("tx_bit_value", {7'd0, tx}, {7'd0, frame[(nt > 9) ? 9 : nt]});
                prev = tx;
            end
        end
        check_int("tx_edge_count", nt, 9);
        check8("tx_idle", {7'd0, tx}, 8'h01);
    endtask

    logic [7:0] r;
    logic [7:0] s1, s2;

    initial begin
        reset_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; rs = 1'b0; rx = 1'b1; din = 8'h00;
        vecs[0] = '{8'h00, 1'b1, 8'h02};
        vecs[1] = '{8'h20, 1'b0, 8'h82};
        vecs[2] = '{8'h40, 1'b1, 8'h02};
        vecs[3] = '{8'h60, 1'b1, 8'h02};
        vecs[4] = '{8'h80, 1'b1, 8'h02};
        vecs[5] = '{8'hA0, 1'b0, 8'h82};
        vecs[6] = '{8'h21, 1'b0, 8'h82};
        vecs[7] = '{8'h23, 1'b1, 8'h02};
        vecs[8] = '{8'h00, 1'b1, 8'h02};

        repeat (3) @(negedge clk);
        check8("reset_tx", {7'd0, tx}, 8'h01);
        check8("reset_irq_n", {7'd0, irq_n}, 8'h01);
        check8("reset_dout", dout, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);
        rd(1'b0, r);
        check8("post_reset_status", r, 8'h02);

        // control value -> IRQ / status with TDRE=1, RDRF=0
        for (int i = 0; i < 9; i++) begin
            wr(1'b0, vecs[i].ctrl);
            check8("vec_irq_n", {7'd0, irq_n}, {7'd0, vecs[i].exp_irq_n});
            rd(1'b0, r);
            check8("vec_status", r, vecs[i].exp_status);
        end

        // TX 0x55; TDRE low for the edge before the shifter takes the byte
        wr(1'b1, 8'h55);
        fork
            tx_monitor(8'h55);
            begin
                rd(1'b0, s1);
                rd(1'b0, s2);
                check8("tdre_before_load", s1 & 8'h02, 8'h00);
                check8("tdre_after_load", s2 & 8'h02, 8'h02);
            end
        join
        @(negedge clk);

        // RX with receive interrupt enabled
        wr(1'b0, 8'h80);
        send_frame(8'hA5, 1'b1);
        check8("rx_irq_n_low", {7'd0, irq_n}, 8'h00);
        rd(1'b0, r);
        check8("rx_status", r, 8'h83);
        rd(1'b1, r);
        check8("rx_data", r, 8'hA5);
        check8("rx_irq_n_high", {7'd0, irq_n}, 8'h01);
        rd(1'b0, r);
        check8("rx_status_after_read", r, 8'h02);

        // overrun
        wr(1'b0, 8'h00);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd(1'b0, r);
        check8("ovrn_status", r, 8'h23);
        rd(1'b1, r);
        check8("ovrn_data", r, 8'h22);
        rd(1'b0, r);
        check8("ovrn_cleared", r, 8'h02);

        // framing error
        send_frame(8'h3C, 1'b0);
        rd(1'b0, r);
        check8("fe_status", r, 8'h13);
        rd(1'b1, r);
        check8("fe_data", r, 8'h3C);

        // master reset with TIE: everything but control cleared, IRQ masked
        wr(1'b0, 8'h23);
        rd(1'b0, r);
        check8("mr_status", r, 8'h02);
        check8("mr_irq_n", {7'd0, irq_n}, 8'h01);
        wr(1'b0, 8'h00);

        // reset in the middle of a frame leaves no partial byte
        send_bit(1'b0, BP);
        send_bit(1'b1, BP);
        send_bit(1'b1, BP);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rx = 1'b1;
        wait_pulses(10 * BP);
        @(negedge clk);
        rd(1'b0, r);
        check8("midframe_reset_status", r, 8'h02);
        rd(1'b1, r);
        check8("midframe_reset_data", r, 8'h00);

        // false start: 8-pulse glitch, then a real frame is still accepted
        send_bit(1'b0, 8);
        send_bit(1'b1, 10 * BP);
        rd(1'b0, r);
        check8("false_start_status", r, 8'h02);
        send_frame(8'h5A, 1'b1);
        rd(1'b0, r);
        check8("after_glitch_status", r, 8'h03);
        rd(1'b1, r);
        check8("after_glitch_data", r, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
